// File: rtl/proctypes.sv
// Shared types for the instruction dispatch path.
// Holds the dispatch FSM encoding and the decoded-instruction width.
package proctypes;

  localparam int DECODED_INST_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNICAST = 2'd1,
    BCAST   = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/inst_dispatch_if.sv
// Upstream instruction handshake and downstream per-core handshake.
// master = the environment around the dispatcher, slave = the dispatcher.
interface inst_dispatch_if #(
  parameter int INST_WIDTH = 64,
  parameter int NUM_CORES  = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] in_inst;
  logic                  in_bcast;
  logic [NUM_CORES-1:0]  core_enable;
  logic [NUM_CORES-1:0]  core_valid;
  logic [NUM_CORES-1:0]  core_ready;
  logic [INST_WIDTH-1:0] core_inst;

  modport master (
    output in_valid,
    output in_inst,
    output in_bcast,
    output core_enable,
    output core_ready,
    input  in_ready,
    input  core_valid,
    input  core_inst
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    input  in_bcast,
    input  core_enable,
    input  core_ready,
    output in_ready,
    output core_valid,
    output core_inst
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rp_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wp_q] = wdata;
        wp_d        = wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_d = rp_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_dispatch.sv
// Buffers decoded instructions and dispatches them to render cores:
// unicast ops round-robin over enabled cores, broadcast ops to all.
module inst_dispatch
  import proctypes::*;
#(
  parameter int INST_WIDTH = DECODED_INST_W,
  parameter int DEPTH      = 8,
  parameter int NUM_CORES  = 4,
  parameter int CNT_WIDTH  = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int TW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk_100mhz,
  input  logic                 rst_n,
  input  logic                 flush,
  inst_dispatch_if.slave       bus,
  output logic [CW-1:0]        fifo_count,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] dispatch_cnt
);

  function automatic logic [TW-1:0] rr_pick(
    input logic [NUM_CORES-1:0] en,
    input logic [TW-1:0]        start
  );
    logic [TW-1:0]        pick;
    logic [NUM_CORES-1:0] sh;
    logic                 found;
    int                   idx;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(start) + i) % NUM_CORES;
      sh  = en >> idx;
      if (!found && sh[0]) begin
        pick  = TW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  dispatch_state_e      state_q, state_d;
  logic [TW-1:0]        tgt_q, tgt_d;
  logic [TW-1:0]        rr_q, rr_d;
  logic [NUM_CORES-1:0] en_q, en_d;
  logic [NUM_CORES-1:0] acc_q, acc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rdy_q;

  logic [INST_WIDTH:0]  head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [NUM_CORES-1:0] cv;
  logic [NUM_CORES-1:0] hs;
  logic                 done;
  logic                 can_load;
  logic [TW-1:0]        pick;
  logic [TW-1:0]        pick_nxt;

  assign bus.in_ready = rdy_q & ~full;
  assign push = bus.in_valid & bus.in_ready & ~flush;

  sync_fifo #(
    .WIDTH (INST_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_bcast, bus.in_inst}),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    unique case (state_q)
      UNICAST: cv = NUM_CORES'(1) << tgt_q;
      BCAST:   cv = en_q & ~acc_q;
      default: cv = '0;
    endcase
  end

  assign hs = cv & bus.core_ready;

  assign done = ((state_q == UNICAST) && (hs != '0)) ||
                ((state_q == BCAST) && ((acc_q | hs) == en_q));

  assign can_load = ((state_q == IDLE) || done) &&
                    !empty && (bus.core_enable != '0);
  assign pop = can_load & ~flush;

  assign pick     = rr_pick(bus.core_enable, rr_q);
  assign pick_nxt = (pick == TW'(NUM_CORES - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rr_d    = rr_q;
    en_d    = en_q;
    acc_d   = acc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    if (done) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      rr_d    = '0;
    end else if (can_load) begin
      inst_d = head[INST_WIDTH-1:0];
      en_d   = bus.core_enable;
      acc_d  = '0;
      if (head[INST_WIDTH]) begin
        state_d = BCAST;
      end else begin
        state_d = UNICAST;
        tgt_d   = pick;
        rr_d    = pick_nxt;
      end
    end else if (done) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (state_q == BCAST) begin
      acc_d = acc_q | hs;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      rr_q    <= '0;
      en_q    <= '0;
      acc_q   <= '0;
      inst_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  assign bus.core_valid = cv;
  assign bus.core_inst  = inst_q;
  assign busy           = (fifo_count != '0) | (state_q != IDLE);
  assign dispatch_cnt   = cnt_q;

endmodule
